// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// Holds RV32I funct3 codes, the FSM state enum and the latched request record.
package lsu_pkg;
  localparam int XLEN      = 32;
  localparam int NUM_LANES = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_e;

  typedef struct packed {
    logic            read;
    logic            write;
    logic [2:0]      func3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  function automatic logic [NUM_LANES-1:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // Exactly one of read/write, and a funct3 defined for that direction.
  function automatic logic f3_legal(input logic rd, input logic wr, input logic [2:0] f3);
    logic ok;
    if (rd) ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
    else    ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    f3_legal = (rd != wr) && ok;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store steering and load assembly/extension.
// Both beats are derived from one 64-bit window spanning two consecutive words.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]           func3,
  input  logic [1:0]           offset,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      rdata_lo,
  input  logic [XLEN-1:0]      rdata_hi,
  output logic [NUM_LANES-1:0] be0,
  output logic [NUM_LANES-1:0] be1,
  output logic [XLEN-1:0]      wdata0,
  output logic [XLEN-1:0]      wdata1,
  output logic                 misaligned,
  output logic [XLEN-1:0]      load_data
);
  logic [2*NUM_LANES-1:0] be_ext;
  logic [2*XLEN-1:0]      wd_ext;
  logic [2*XLEN-1:0]      rd_ext;
  logic [XLEN-1:0]        rd_raw;

  always_comb begin
    be_ext = {4'b0000, size_mask(func3)} << offset;
    wd_ext = {32'h0, wdata} << {offset, 3'b000};
    rd_ext = {rdata_hi, rdata_lo} >> {offset, 3'b000};
    rd_raw = rd_ext[XLEN-1:0];
    case (func3)
      F3_LB:   load_data = {{24{rd_raw[7]}}, rd_raw[7:0]};
      F3_LH:   load_data = {{16{rd_raw[15]}}, rd_raw[15:0]};
      F3_LBU:  load_data = {24'h0, rd_raw[7:0]};
      F3_LHU:  load_data = {16'h0, rd_raw[15:0]};
      default: load_data = rd_raw;
    endcase
  end

  assign be0        = be_ext[NUM_LANES-1:0];
  assign be1        = be_ext[2*NUM_LANES-1:NUM_LANES];
  assign wdata0     = wd_ext[XLEN-1:0];
  assign wdata1     = wd_ext[2*XLEN-1:XLEN];
  assign misaligned = |be1;
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, one or two word beats to memory,
// single-cycle response pulse. Memory-side outputs are registered and held until ack.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  lsu_state_e state, state_nx;
  lsu_req_t   req_q, cur;
  logic       mis_q;
  logic [31:0] rdata0_q;

  logic        accept, mem_fire, req_err;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1, load_data;
  logic        misaligned;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_fire  = mem_req && mem_ack;

  // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
  always_comb begin
    cur = req_q;
    if (state == IDLE) begin
      cur.read  = req_read;
      cur.write = req_write;
      cur.func3 = req_func3;
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
    end
  end

  lsu_align u_align (
    .func3      (cur.func3),
    .offset     (cur.addr[1:0]),
    .wdata      (cur.wdata),
    .rdata_lo   ((state == BEAT1) ? rdata0_q : mem_rdata),
    .rdata_hi   ((state == BEAT1) ? mem_rdata : 32'h0),
    .be0        (be0),
    .be1        (be1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .misaligned (misaligned),
    .load_data  (load_data)
  );

  assign req_err = !f3_legal(req_read, req_write, req_func3) ||
                   (misaligned && (ALLOW_MISALIGNED == 0));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept)   state_nx = req_err ? RESP : BEAT0;
      BEAT0: if (mem_fire) state_nx = mis_q ? BEAT1 : RESP;
      BEAT1: if (mem_fire) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q      <= '0;
      mis_q      <= 1'b0;
      rdata0_q   <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          req_q <= cur;
          mis_q <= misaligned;
          if (req_err) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= req_write;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= be0;
            mem_wdata <= wdata0;
          end
        end
        BEAT0: if (mem_fire) begin
          rdata0_q <= mem_rdata;
          if (mis_q) begin
            mem_we    <= req_q.write;
            mem_addr  <= {req_q.addr[31:2], 2'b00} + 32'd4;
            mem_be    <= be1;
            mem_wdata <= wdata1;
          end else begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'h0;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= req_q.read ? load_data : 32'h0;
          end
        end
        BEAT1: if (mem_fire) begin
          mem_req    <= 1'b0;
          mem_we     <= 1'b0;
          mem_be     <= 4'h0;
          mem_wdata  <= 32'h0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= req_q.read ? load_data : 32'h0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; a second instance with ALLOW_MISALIGNED=0
// shares the stimulus to cover the strict misalignment path.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic [2:0]  req_func3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        s_req_ready, s_resp_valid, s_resp_err, s_mem_req, s_mem_we;
  logic [31:0] s_resp_rdata, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.ALLOW_MISALIGNED(0)) dut_strict (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_read(req_read), .req_write(req_write), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(s_resp_valid),
    .resp_rdata(s_resp_rdata), .resp_err(s_resp_err), .mem_req(s_mem_req),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_be(s_mem_be), .mem_wdata(s_mem_wdata),
    .mem_ack(mem_ack & s_mem_req), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns in cycle N+1.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_func3 = f3; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
  endtask

  // Checks one memory beat, holds it for `waits` cycles, then acks with rd.
  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                      input logic we, input logic [31:0] wd, input logic [31:0] rd,
                      input int waits);
    check({tag, ".req"},   32'(mem_req), 32'd1);
    check({tag, ".addr"},  mem_addr, a);
    check({tag, ".be"},    32'(mem_be), 32'(be));
    check({tag, ".we"},    32'(mem_we), 32'(we));
    check({tag, ".wdata"}, mem_wdata, wd);
    for (int i = 0; i < waits; i++) begin
      step();
      check({tag, ".hold_addr"}, mem_addr, a);
      check({tag, ".hold_be"},   32'(mem_be), 32'(be));
      check({tag, ".hold_rv"},   32'(resp_valid), 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = rd;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic resp(input string tag, input logic [31:0] rd, input logic err);
    check({tag, ".rv"},    32'(resp_valid), 32'd1);
    check({tag, ".rdata"}, resp_rdata, rd);
    check({tag, ".err"},   32'(resp_err), 32'(err));
    check({tag, ".ready"}, 32'(req_ready), 32'd0);
    step();
    check({tag, ".rv_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, ".idle"},     32'(req_ready), 32'd1);
  endtask

  initial begin
    step(); step();
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.rv",    32'(resp_valid), 32'd0);
    check("rst.mreq",  32'(mem_req), 32'd0);
    check("rst.addr",  mem_addr, 32'h0);
    check("rst.be",    32'(mem_be), 32'h0);
    check("rst.rdata", resp_rdata, 32'h0);
    rst_n = 1'b1;
    step();

    issue(1, 0, F3_LW, 32'h100, 32'h0);
    beat("lw", 32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 0);
    check("lw.mreq_drop", 32'(mem_req), 32'd0);
    resp("lw", 32'hDEADBEEF, 1'b0);

    issue(1, 0, F3_LB, 32'h103, 32'h0);
    beat("lb", 32'h100, 4'b1000, 1'b0, 32'h0, 32'h80000000, 0);
    resp("lb", 32'hFFFFFF80, 1'b0);
    issue(1, 0, F3_LBU, 32'h103, 32'h0);
    beat("lbu", 32'h100, 4'b1000, 1'b0, 32'h0, 32'h80000000, 0);
    resp("lbu", 32'h00000080, 1'b0);

    issue(0, 1, F3_SW, 32'h102, 32'hAABBCCDD);
    beat("sw.b0", 32'h100, 4'b1100, 1'b1, 32'hCCDD0000, 32'h12345678, 0);
    check("sw.no_early_rv", 32'(resp_valid), 32'd0);
    beat("sw.b1", 32'h104, 4'b0011, 1'b1, 32'h0000AABB, 32'h12345678, 0);
    resp("sw", 32'h0, 1'b0);

    issue(1, 0, F3_LH, 32'hFFFFFFFF, 32'h0);
    beat("lh.b0", 32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0, 32'h11000000, 0);
    beat("lh.b1", 32'h00000000, 4'b0001, 1'b0, 32'h0, 32'h00000022, 0);
    resp("lh", 32'h00002211, 1'b0);

    // Wait states, with a competing request held on the inputs while busy.
    issue(1, 0, F3_LH, 32'h102, 32'h0);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
    req_func3 = F3_SB; req_addr = 32'h555; req_wdata = 32'hFF;
    beat("lhw", 32'h100, 4'b1100, 1'b0, 32'h0, 32'h80010000, 2);
    req_valid = 1'b0; req_write = 1'b0;
    resp("lhw", 32'hFFFF8001, 1'b0);

    issue(1, 0, 3'b011, 32'h100, 32'h0);
    check("badf3.mreq", 32'(mem_req), 32'd0);
    resp("badf3", 32'h0, 1'b1);
    issue(1, 1, F3_LW, 32'h100, 32'h0);
    check("rdwr.mreq", 32'(mem_req), 32'd0);
    resp("rdwr", 32'h0, 1'b1);

    issue(0, 1, F3_SH, 32'h101, 32'h0000BEEF);
    beat("sh", 32'h100, 4'b0110, 1'b1, 32'h00BEEF00, 32'h0, 0);
    resp("sh", 32'h0, 1'b0);

    // Misaligned LW: strict instance rejects, permissive instance splits.
    issue(1, 0, F3_LW, 32'h101, 32'h0);
    check("strict.mreq", 32'(s_mem_req), 32'd0);
    check("strict.rv",   32'(s_resp_valid), 32'd1);
    check("strict.err",  32'(s_resp_err), 32'd1);
    check("strict.rd",   s_resp_rdata, 32'h0);
    beat("lwm.b0", 32'h100, 4'b1110, 1'b0, 32'h0, 32'h332211AA, 0);
    check("strict.idle", 32'(s_req_ready), 32'd1);
    beat("lwm.b1", 32'h104, 4'b0001, 1'b0, 32'h0, 32'hEEEEEE44, 0);
    resp("lwm", 32'h44332211, 1'b0);

    issue(1, 0, F3_LW, 32'h200, 32'h0);
    check("abort.mreq", 32'(mem_req), 32'd1);
    step(); step();
    rst_n = 1'b0;
    step();
    check("abort.mreq_drop", 32'(mem_req), 32'd0);
    check("abort.rv",        32'(resp_valid), 32'd0);
    check("abort.ready",     32'(req_ready), 32'd1);
    check("abort.s_mreq",    32'(s_mem_req), 32'd0);
    rst_n = 1'b1;
    step();
    check("abort.rv_after",   32'(resp_valid), 32'd0);
    step();
    check("abort.mreq_after", 32'(mem_req), 32'd0);
    check("abort.rv_after2",  32'(resp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
